// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR types, defaults, prototype coefficients and fixed-point helpers
package fir_pkg;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2
    } interp_state_t;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_TAPS          = 32;
    localparam int DEFAULT_INTERPOLATION = 4;
    localparam int DEFAULT_FRAC_BITS     = 10;

    // Widest product any FIR variant may hand to dequantize (2 x 64-bit operands).
    localparam int MAX_PROD_W = 128;

    localparam logic [0:DEFAULT_TAPS-1][DEFAULT_DATA_WIDTH-1:0] COEFF_LP32 = {
        32'hffffffff, 32'h00000000, 32'h00000000, 32'h00000002,
        32'h00000004, 32'h00000008, 32'h0000000b, 32'h0000000c,
        32'h00000008, 32'hfffffffd, 32'hffffffea, 32'hffffffd1,
        32'hffffffb9, 32'hffffffa8, 32'hffffff76, 32'hffffffa6,
        32'h00000078, 32'h0000017c, 32'h0000028a, 32'h00000334,
        32'h00000334, 32'h0000028a, 32'h0000017c, 32'h00000078,
        32'hffffffa6, 32'hffffff76, 32'hffffffa8, 32'hffffffb9,
        32'hffffffd1, 32'hffffffea, 32'hfffffffd, 32'h00000008
    };

    // Negative products get a bias of 2^frac-1 so the arithmetic shift rounds toward zero.
    function automatic logic signed [MAX_PROD_W-1:0] dequantize(
        input logic signed [MAX_PROD_W-1:0] prod,
        input int                           frac_bits
    );
        logic signed [MAX_PROD_W-1:0] bias;
        bias = prod[MAX_PROD_W-1] ? ((MAX_PROD_W'(1) << frac_bits) - MAX_PROD_W'(1)) : '0;
        return (prod + bias) >>> frac_bits;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - combinational multiply-accumulate: acc + dequantize(coeff * sample)
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0] acc,
    input  logic signed [DATA_WIDTH-1:0] coeff,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] acc_next
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [MAX_PROD_W-1:0]   prod_ext;
    logic signed [MAX_PROD_W-1:0]   scaled;

    always_comb begin
        prod     = coeff * sample;
        prod_ext = MAX_PROD_W'(prod);
        scaled   = dequantize(prod_ext, FRAC_BITS);
        // Truncation to DATA_WIDTH gives wrap-around accumulation.
        acc_next = acc + scaled[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/fir_interp.sv
// rtl/fir_interp.sv - polyphase interpolating FIR, one MAC per clock, FIFO in and out
module fir_interp
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int TAPS          = DEFAULT_TAPS,
    parameter int INTERPOLATION = DEFAULT_INTERPOLATION,
    parameter int FRAC_BITS     = DEFAULT_FRAC_BITS,
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] COEFF = COEFF_LP32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  x_in_rd_en,
    input  logic                  x_in_empty,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_wr_en,
    input  logic                  y_out_full
);

    localparam int P     = TAPS / INTERPOLATION;
    localparam int K_W   = (P > 1) ? $clog2(P) : 1;
    localparam int PH_W  = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    interp_state_t                 state_q, state_d;
    logic [K_W-1:0]                k_q, k_d;
    logic [PH_W-1:0]               phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]         y_q, y_d;
    logic signed [DATA_WIDTH-1:0]  x_q [P];
    logic signed [DATA_WIDTH-1:0]  x_d [P];

    logic                          rd_en_c;
    logic                          wr_en_c;
    logic [TAP_W-1:0]              tap_idx;
    logic signed [DATA_WIDTH-1:0]  coeff_sel;
    logic signed [DATA_WIDTH-1:0]  sample_sel;
    logic signed [DATA_WIDTH-1:0]  mac_out;

    // Prototype tap for (k, phase) sits at k*L + phase.
    assign tap_idx    = TAP_W'(k_q) * TAP_W'(INTERPOLATION) + TAP_W'(phase_q);
    assign coeff_sel  = COEFF[tap_idx];
    assign sample_sel = x_q[k_q];

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .acc      (acc_q),
        .coeff    (coeff_sel),
        .sample   (sample_sel),
        .acc_next (mac_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        y_d     = y_q;
        x_d     = x_q;
        rd_en_c = 1'b0;
        wr_en_c = 1'b0;

        case (state_q)
            READ: begin
                if (!x_in_empty) begin
                    rd_en_c = 1'b1;
                    x_d[0]  = x_in;
                    for (int i = 1; i < P; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    phase_d = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d = mac_out;
                k_d   = k_q + K_W'(1);
                if (k_q == K_W'(P - 1)) begin
                    y_d     = mac_out;
                    k_d     = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!y_out_full) begin
                    wr_en_c = 1'b1;
                    if (phase_q == PH_W'(INTERPOLATION - 1)) begin
                        state_d = READ;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = READ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= READ;
            k_q     <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            for (int i = 0; i < P; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            for (int i = 0; i < P; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    // Strobes are combinational, so they are gated to stay low while reset is held.
    assign x_in_rd_en  = rd_en_c & ~reset;
    assign y_out_wr_en = wr_en_c & ~reset;
    assign y_out       = y_q;

endmodule

// File: doc/fir_interp.md
# fir_interp

Polyphase interpolating FIR filter: reads one sample from an upstream FIFO and writes INTERPOLATION filtered samples to a downstream FIFO. It is the upsampling counterpart of the decimating channel FIR in the FM radio datapath. It is used where a stream must be raised to a higher rate, for example before the audio output or resampling stage. Arithmetic is signed fixed-point with FRAC_BITS fractional bits, and the block performs one multiply-accumulate per clock.

## Interface
- DATA_WIDTH, 32: sample and coefficient width, signed.
- TAPS, 32: total prototype filter length. Must be a multiple of INTERPOLATION.
- INTERPOLATION, 4: upsampling factor L. Phase length is P = TAPS/L.
- FRAC_BITS, 10: fixed-point fraction bits.
- COEFF, fir_pkg::COEFF_LP32: [0:TAPS-1][DATA_WIDTH-1:0] prototype coefficients. Default values begin 0xffffffff, 0, 0, 0x2, 0x4, 0x8, 0xb, 0xc.

Ports:
- clock  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high.
- x_in  in  DATA_WIDTH  input sample. The upstream FIFO is first-word-fall-through, so data is valid whenever x_in_empty=0.
- x_in_rd_en  out  1  pop strobe for the input FIFO.
- x_in_empty  in  1  input FIFO empty flag.
- y_out  out  DATA_WIDTH  output sample (registered).
- y_out_wr_en  out  1  push strobe for the output FIFO.
- y_out_full  in  1  output FIFO full flag.

## Operation
- Delay line: x[0:P-1], where x[0] holds the newest sample.
- Per-phase output: for phase p in 0..L-1, y_p = sum over k=0..P-1 of mul(COEFF[k*L+p], x[k]).
- mul: form the full 2*DATA_WIDTH signed product. If the product is negative, add 2^FRAC_BITS-1. Then arithmetic shift right by FRAC_BITS and truncate to DATA_WIDTH. This rounds toward zero.
- Accumulator: DATA_WIDTH signed. Overflow wraps with no saturation.
- No gain compensation for L. Coefficients carry any required gain.
- State machine (fir_pkg::interp_state_t):
  - READ: if x_in_empty=0, assert x_in_rd_en combinationally, shift x_in into x[0] (x[k] <= x[k-1]), clear the accumulator and k, set phase=0, go to COMPUTE. Otherwise stay in READ.
  - COMPUTE: acc <= acc + mul(COEFF[k*L+phase], x[k]) and k <= k+1. When k=P-1, register the final sum into y_out and go to WRITE.
  - WRITE: if y_out_full=0, assert y_out_wr_en combinationally. Then, if phase=L-1, go to READ; otherwise phase <= phase+1, clear acc and k, and go to COMPUTE. If full, stay in WRITE with y_out held.
- An illegal state returns to READ. All strobes are deasserted in that cycle.
- x_in_rd_en is only ever asserted in READ and y_out_wr_en only in WRITE. The two are never high in the same cycle.
- The delay line changes only in READ, so backpressure never corrupts state.

## Timing
- Reset values: y_out=0, y_out_wr_en=0, x_in_rd_en=0, delay line=0, acc=0, k=0, phase=0, state=READ. Reset takes effect immediately, including mid-COMPUTE or mid-WRITE. A pending output is discarded.
- Input to first output: 1 READ cycle + P COMPUTE cycles. y_out_wr_en is high on cycle P+1 after the read cycle (P=8, so cycle 9).
- Between outputs of one input sample: P+1 cycles minimum.
- Minimum cycles per input sample: 1 + L*(P+1). The default is 37.
- Every stall extends this by exactly the stall length:
  - x_in_empty high: stall in READ.
  - y_out_full high: stall in WRITE.
- y_out is stable from entry to WRITE until the next COMPUTE completes.

## Structure
- fir_pkg holds:
  - interp_state_t {READ, COMPUTE, WRITE}
  - FRAC_BITS default
  - COEFF_LP32 constant
  - the dequantize/mul function, which the decimating FIR also uses.
- Sub-module fir_mac (combinational) takes acc, coeff and sample and returns acc + mul(coeff, sample). It is reusable by other FIR variants.
- The top level holds the FSM, the counters (k, phase) and the delay line.

## Test plan
- Impulse: input 0x00000400 (1.0) followed by 8 zeros.
  - Required: exactly 32 outputs equal to COEFF[0..31] in order (0xffffffff, 0, 0, 0x2, 0x4, ...), then 4 outputs of 0 per further zero input.
- Sign and rounding:
  - Impulse 0xfffffc00 (-1.0): outputs equal -COEFF[n] (0x1, 0, 0, 0xfffffffe, ...).
  - Impulse 0x00000001: all 32 outputs are 0, because -138*1 rounds toward zero.
- Input starvation: hold x_in_empty=1 for 50 cycles between samples.
  - Required: no x_in_rd_en and no y_out_wr_en during the gap.
  - Required: the output sequence is identical to the unstalled run.
- Output backpressure: hold y_out_full=1 for 20 cycles while in WRITE.
  - Required: y_out_wr_en=0 and y_out constant for the whole stall.
  - Required: exactly one write of that value after release, with no drop and no duplicate.
- Reset mid-operation: assert reset during COMPUTE of phase 2.
  - Required: all outputs are 0 in the same cycle and state is READ.
  - Required: a following impulse reproduces the clean 32-coefficient sequence.
- Throughput: random stream with empty and full never asserted.
  - Required: one x_in_rd_en every 37 cycles and 4 writes per read.
  - Required: results match a bit-exact reference model.
